// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one UART TX FIFO among NREQ byte streams.
// Pushes are registered, and the arbiter only accepts a byte while the FIFO has room for it.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int HDR_EN     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  input  logic [CNT_W-1:0]    tf_count,
  output logic [7:0]          tdr,
  output logic                tf_push,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [2:0]   grant_q, grant_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [7:0]   tdr_q, tdr_d;
  logic         tf_push_q, tf_push_d;

  logic [CNT_W:0] fill;
  logic           space;
  logic           pick_found;
  logic [2:0]     pick_idx;
  logic [3:0]     cand;
  logic           cur_valid, cur_last;
  logic [7:0]     cur_data;

  // tf_count lags our own push by a cycle, so the in-flight push is counted as occupied.
  assign fill  = {1'b0, tf_count} + {{CNT_W{1'b0}}, tf_push_q};
  assign space = (fill < (CNT_W+1)'(FIFO_DEPTH));

  // First valid requester scanning ptr+1, ptr+2, ... modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && (cand == 4'(i)) && req_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  // Handshake: a byte of requester i transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; ready never depends on req_valid, only on grant and FIFO room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == S_DATA) && space && (grant_q == 3'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tdr_d     = tdr_q;
    tf_push_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = (HDR_EN != 0) ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        if (space) begin
          tf_push_d = 1'b1;
          tdr_d     = {5'b10100, grant_q};
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (space && cur_valid) begin
          tf_push_d = 1'b1;
          tdr_d     = cur_data;
          if (cur_last) begin
            ptr_d   = grant_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= 3'(NREQ-1);
      tdr_q     <= '0;
      tf_push_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tdr_q     <= tdr_d;
      tf_push_q <= tf_push_d;
    end
  end

  assign tdr       = tdr_q;
  assign tf_push   = tf_push_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin reference model feeding a scoreboard,
// a small UART FIFO model for tf_count, plus a header-less instance for directed checks.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (header enabled) ----------------
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ-1:0]   req_ready;
  logic [CNT_W-1:0]  tf_count  = '0;
  logic [7:0]        tdr;
  logic              tf_push;
  logic [2:0]        grant_id;
  logic              busy;
  logic [1:0]        dbg_state;

  uart_tx_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .HDR_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tf_count(tf_count), .tdr(tdr), .tf_push(tf_push),
    .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (no header) ----------------
  logic [NREQ-1:0]   b_valid = '0;
  logic [8*NREQ-1:0] b_data  = '0;
  logic [NREQ-1:0]   b_last  = '0;
  logic [NREQ-1:0]   b_ready;
  logic [CNT_W-1:0]  b_count = '0;
  logic [7:0]        b_tdr;
  logic              b_push;
  logic [2:0]        b_grant;
  logic              b_busy;
  logic [1:0]        b_state;

  uart_tx_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .HDR_EN(0)) dut_nohdr (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .tf_count(b_count), .tdr(b_tdr), .tf_push(b_push),
    .grant_id(b_grant), .busy(b_busy), .dbg_state(b_state)
  );

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  exp_q[$];            // {is_header, byte}
  int          push_cyc_q[$];
  int          cyc = 0;
  logic [8:0]  mon_e;
  logic [7:0]  drv_bytes[NREQ][$];
  int          drv_lens[NREQ][$];
  int          cur_off[NREQ];
  int          hold_off[NREQ];
  int          bubble_pct = 0;
  int          drain_pct  = 100;
  int          m_ptr      = NREQ-1;
  int          occ        = 0;
  int          occ_next   = 0;
  bit          pop;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  // Whole packets, round-robin from the last finished requester; header then payload.
  task automatic model_phase();
    int poff[NREQ];
    int boff[NREQ];
    int pick;
    int len;
    for (int r = 0; r < NREQ; r++) begin
      poff[r] = 0;
      boff[r] = 0;
    end
    while (1) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int r = (m_ptr + k) % NREQ;
        if (pick < 0 && poff[r] < drv_lens[r].size()) pick = r;
      end
      if (pick < 0) break;
      len = drv_lens[pick][poff[pick]];
      exp_q.push_back({1'b1, 8'hA0 + 8'(pick)});
      for (int j = 0; j < len; j++) exp_q.push_back({1'b0, drv_bytes[pick][boff[pick] + j]});
      boff[pick] += len;
      poff[pick]++;
      m_ptr = pick;
    end
  endtask

  // ---------------- driver ----------------
  task automatic add_pkt(int r, int len, int base);
    drv_lens[r].push_back(len);
    for (int j = 0; j < len; j++)
      drv_bytes[r].push_back((base < 0) ? 8'($urandom) : 8'(base * (j + 1)));
  endtask

  function automatic bit pending();
    for (int r = 0; r < NREQ; r++) if (drv_lens[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    bit v;
    for (int r = 0; r < NREQ; r++) begin
      v = 1'b0;
      if (drv_lens[r].size() > 0) begin
        v = 1'b1;
        if (cur_off[r] > 0) begin
          if (hold_off[r] > 0) begin
            v = 1'b0;
            hold_off[r]--;
          end else if ($urandom_range(0, 99) < bubble_pct) v = 1'b0;
        end
      end
      req_valid[r]        = v;
      req_data[8*r +: 8]  = v ? drv_bytes[r][0] : 8'($urandom);
      req_last[r]         = v ? (cur_off[r] == drv_lens[r][0] - 1) : 1'($urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          void'(drv_bytes[r].pop_front());
          cur_off[r]++;
          if (cur_off[r] == drv_lens[r][0]) begin
            void'(drv_lens[r].pop_front());
            cur_off[r] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic flush_all();
    for (int r = 0; r < NREQ; r++) begin
      drv_bytes[r].delete();
      drv_lens[r].delete();
      cur_off[r]  = 0;
      hold_off[r] = 0;
    end
    exp_q.delete();
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((pending() || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      fail_now({name, "_timeout"});
      flush_all();
    end
    check({name, "_busy_after"}, busy, 0);
  endtask

  // ---------------- UART FIFO model + monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tf_push) begin
        push_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_push: got tdr 0x%0h, expected no push", tdr);
        end else begin
          mon_e = exp_q.pop_front();
          check("tdr", tdr, mon_e[7:0]);
          if (mon_e[8]) check("hdr_grant_id", grant_id, mon_e[2:0]);
        end
      end
      check("fifo_bound", (occ + tf_push <= DEPTH), 1);
      if (occ + tf_push >= DEPTH) check("full_ready", req_ready, 0);
    end
    pop      = (occ > 0) && ($urandom_range(0, 99) < drain_pct);
    occ_next = occ + tf_push - pop;
  end

  always @(posedge clk) begin
    #2;
    occ      = occ_next;
    tf_count = occ[CNT_W-1:0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tdr", tdr, 0);
    check("rst_push", tf_push, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // header-less instance: 2-byte packet from requester 3
    @(posedge clk); #1;
    b_valid = 4'b1000; b_data[31:24] = 8'h5A; b_last = 4'b0000;
    @(negedge clk);
    check("b_idle_ready", b_ready, 0);
    check("b_idle_push", b_push, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_data_ready", b_ready, 4'b1000);
    check("b_busy", b_busy, 1);
    check("b_nopush_yet", b_push, 0);
    @(posedge clk); #1;
    b_data[31:24] = 8'hC3; b_last = 4'b1000;
    @(negedge clk);
    check("b_push1", b_push, 1);
    check("b_tdr1", b_tdr, 8'h5A);
    check("b_ready2", b_ready, 4'b1000);
    @(posedge clk); #1;
    b_valid = '0; b_last = '0;
    @(negedge clk);
    check("b_push2", b_push, 1);
    check("b_tdr2", b_tdr, 8'hC3);
    check("b_busy_end", b_busy, 0);
    check("b_ready_end", b_ready, 0);
    check("b_grant", b_grant, 3);
    @(negedge clk);
    check("b_no_third_push", b_push, 0);
    @(posedge clk); #1;

    // round-robin from reset: 1-byte packets on all requesters, two on requester 0
    bubble_pct = 0; drain_pct = 100;
    add_pkt(0, 1, -1); add_pkt(0, 1, -1);
    for (int r = 1; r < NREQ; r++) add_pkt(r, 1, -1);
    model_phase();
    wait_drain("rr", 200);

    // single requester, 3 bytes back to back after the header
    add_pkt(2, 3, 'h11);
    model_phase();
    push_cyc_q.delete();
    wait_drain("single", 100);
    check("single_push_count", push_cyc_q.size(), 4);
    if (push_cyc_q.size() == 4) check("single_consecutive", push_cyc_q[3] - push_cyc_q[0], 3);
    check("single_grant", grant_id, 2);

    // packet lock: requester 1 stalls mid-packet while requester 0 keeps asking
    add_pkt(0, 2, -1); add_pkt(0, 3, -1);
    add_pkt(1, 4, -1);
    hold_off[1] = 5;
    model_phase();
    n = 0;
    while ((pending() || exp_q.size() > 0) && n < 300) begin
      cycle();
      n++;
      if (cur_off[1] > 0) check("lock_grant", grant_id, 1);
    end
    wait_drain("lock", 10);

    // backpressure: FIFO stops draining, fills, then drains slowly
    drain_pct = 0;
    for (int r = 0; r < NREQ; r++) add_pkt(r, 8, -1);
    model_phase();
    repeat (80) cycle();
    check("bp_full_occ", occ, DEPTH);
    check("bp_ready_low", req_ready, 0);
    drain_pct = 30;
    wait_drain("bp", 3000);

    // randomized traffic
    for (int ph = 0; ph < 6; ph++) begin
      bubble_pct = 30;
      drain_pct  = $urandom_range(20, 100);
      for (int r = 0; r < NREQ; r++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) add_pkt(r, $urandom_range(1, 6), -1);
      end
      model_phase();
      wait_drain("rand", 3000);
    end

    // reset in the middle of a 5-byte packet
    bubble_pct = 0; drain_pct = 100;
    add_pkt(2, 5, -1);
    model_phase();
    n = 0;
    while (cur_off[2] < 2 && n < 50) begin
      cycle();
      n++;
    end
    if (n >= 50) fail_now("midrst_progress");
    rst = 1'b1;
    flush_all();
    m_ptr = NREQ-1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_push", tf_push, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_grant", grant_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    add_pkt(3, 1, -1);
    add_pkt(0, 1, -1);
    model_phase();
    drive();
    wait_drain("after_rst", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
